// File: rtl/nibble_serial_adder.sv
// Bit-serial-by-nibble adder/subtractor: one shared 4-bit adder, one nibble per cycle, LSB first.
// Valid/ready handshake on both sides; results held in output registers until overwritten.

module adder_4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c3_o,
  output logic       c_o
);
  logic [4:0] c;

  always_comb begin
    c    = '0;
    s_o  = '0;
    c[0] = c_i;
    for (int i = 0; i < 4; i++) begin
      s_o[i]  = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]  = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    c3_o = c[3];
    c_o  = c[4];
  end
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  input  logic             carry_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH % 4 != 0) || (WIDTH < 8)) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic             init_q, init_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic             cy_q, cy_d, co_q, co_d, ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [3:0] nib_sum;
  logic       nib_c3, nib_c4, last_nib;

  adder_4 u_add (
    .a_i  (a_q[3:0]),
    .b_i  (b_q[3:0]),
    .c_i  (cy_q),
    .s_o  (nib_sum),
    .c3_o (nib_c3),
    .c_o  (nib_c4)
  );

  assign last_nib = (cnt_q == CW'(NIB - 1));

  always_comb begin
    state_d     = state_q;
    init_d      = 1'b1;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    sum_d       = sum_q;
    cy_d        = cy_q;
    co_d        = co_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    in_ready_o  = (state_q == IDLE) && init_q;
    out_valid_o = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (in_valid_i && in_ready_o) begin
          a_d     = a_i;
          b_d     = sub_i ? ~b_i : b_i;
          cy_d    = sub_i ? 1'b1 : carry_i;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d = {nib_sum, res_q[WIDTH-1:4]};
        a_d   = a_q >> 4;
        b_d   = b_q >> 4;
        cy_d  = nib_c4;
        if (last_nib) begin
          // Publish only on completion so outputs never show partial sums.
          cnt_d   = '0;
          sum_d   = {nib_sum, res_q[WIDTH-1:4]};
          co_d    = nib_c4;
          ovf_d   = nib_c3 ^ nib_c4;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      init_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cy_q    <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cy_q    <= cy_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sum_o      = sum_q;
  assign carry_o    = co_q;
  assign overflow_o = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: directed corner cases, backpressure, mid-run reset, random ops.

module tb_nibble_serial_adder;
  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic [W-1:0] a_i = '0, b_i = '0;
  logic         sub_i = 1'b0, carry_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0;
  logic         in_ready_o, carry_o, overflow_o, out_valid_o;
  logic [W-1:0] sum_o;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cy;
    logic         ovf;
  } res_t;

  res_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .a_i         (a_i),
    .b_i         (b_i),
    .sub_i       (sub_i),
    .carry_i     (carry_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .sum_o       (sum_o),
    .carry_o     (carry_o),
    .overflow_o  (overflow_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sub, input logic cin);
    res_t         r;
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb    = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    r.sum = full[W-1:0];
    r.cy  = full[W];
    r.ovf = (a[W-1] == bb[W-1]) && (r.sum[W-1] != a[W-1]);
    return r;
  endfunction

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic cin, input int stall);
    int   n;
    res_t e;
    logic [W-1:0] held;
    n = 0;
    @(negedge clk_i);
    while (!in_ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("in_ready_wait", {63'b0, in_ready_o}, 64'd1);
    a_i = a; b_i = b; sub_i = sub; carry_i = cin; in_valid_i = 1'b1;
    exp_q.push_back(ref_op(a, b, sub, cin));
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    a_i = $urandom; b_i = $urandom; sub_i = ~sub; carry_i = ~cin;
    n = 0;
    while (!out_valid_o && n < 20) begin
      @(posedge clk_i); #1;
      n++;
      a_i = $urandom; b_i = $urandom;
    end
    chk("latency", 64'(n), 64'd8);
    e = exp_q.pop_front();
    chk("sum", 64'(sum_o), 64'(e.sum));
    chk("carry", {63'b0, carry_o}, {63'b0, e.cy});
    chk("ovf", {63'b0, overflow_o}, {63'b0, e.ovf});
    held = sum_o;
    for (int k = 0; k < stall; k++) begin
      @(posedge clk_i); #1;
      a_i = $urandom; b_i = $urandom;
      chk("stall_valid", {63'b0, out_valid_o}, 64'd1);
      chk("stall_ready", {63'b0, in_ready_o}, 64'd0);
      chk("stall_sum", 64'(sum_o), 64'(held));
    end
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
    chk("post_valid", {63'b0, out_valid_o}, 64'd0);
    chk("post_ready", {63'b0, in_ready_o}, 64'd1);
    chk("idle_hold", 64'(sum_o), 64'(held));
  endtask

  initial begin
    int n;
    #12;
    chk("rst_ready", {63'b0, in_ready_o}, 64'd0);
    chk("rst_valid", {63'b0, out_valid_o}, 64'd0);
    chk("rst_sum", 64'(sum_o), 64'd0);
    chk("rst_cy_ovf", {62'b0, carry_o, overflow_o}, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("first_ready", {63'b0, in_ready_o}, 64'd1);

    do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 0);
    do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1);
    do_op(32'h00000005, 32'h00000007, 1'b1, 1'b0, 0);
    do_op(32'h80000000, 32'h00000001, 1'b1, 1'b1, 0);
    do_op(32'h0000000F, 32'h00000000, 1'b0, 1'b1, 5);

    // Abort in the fourth RUN cycle.
    @(negedge clk_i);
    a_i = 32'hAAAA5555; b_i = 32'h12345678; sub_i = 1'b0; in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #3;
    chk("abort_valid", {63'b0, out_valid_o}, 64'd0);
    chk("abort_sum", 64'(sum_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk_i); #1;
      if (out_valid_o) n++;
    end
    chk("abort_no_result", 64'(n), 64'd0);
    do_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 0);
    chk("after_abort_sum", 64'(sum_o), 64'h23456789);

    for (int i = 0; i < 1000; i++) begin
      do_op($urandom, $urandom, 1'(($urandom) & 1), 1'(($urandom) & 1),
            int'($urandom_range(0, 3)));
    end

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 a_i  input  WIDTH  operand A.
REQ-005 b_i  input  WIDTH  operand B.
REQ-006 sub_i  input  1  0 = A+B+carry_i, 1 = A-B (carry_i ignored).
REQ-007 carry_i  input  1  carry-in for add mode.
REQ-008 in_valid_i  input  1  operands valid.
REQ-009 in_ready_o  output  1  block can accept operands.
REQ-010 sum_o  output  WIDTH  result.
REQ-011 carry_o  output  1  carry out of MSB (sub mode: 1 = no borrow).
REQ-012 overflow_o  output  1  signed overflow of the result.
REQ-013 out_valid_o  output  1  result valid.
REQ-014 out_ready_i  input  1  consumer accepts result.

Function
REQ-015 Datapath SHALL use exactly one instance of the existing adder_4 block, processing one 4-bit nibble per cycle, LSB nibble first.
REQ-016 FSM states: IDLE, RUN, DONE; IDLE -> RUN on in_valid_i && in_ready_o; RUN -> DONE after the last nibble; DONE -> IDLE on out_ready_i.
REQ-017 in_ready_o SHALL be 1 only in IDLE; out_valid_o SHALL be 1 only in DONE.
REQ-018 On input handshake: latch a_i, b_i (b inverted when sub_i=1) into shift registers; load the carry register with carry_i (add) or 1 (sub); clear the nibble counter.
REQ-019 Each RUN cycle: feed the current low nibbles and the carry register to adder_4, shift its 4-bit sum into the result register from the top, store its carry-out in the carry register, increment the counter.
REQ-020 Latency: out_valid_o SHALL rise exactly WIDTH/4 cycles after the input-handshake edge (8 cycles for WIDTH=32).
REQ-021 carry_o SHALL equal the carry-out of the final nibble; overflow_o SHALL equal carry-into-MSB XOR carry-out-of-MSB, taken from the final nibble's internal carries (sum sign vs operand signs is an equivalent check).
REQ-022 sum_o, carry_o, overflow_o SHALL be stable throughout DONE, until the output handshake completes, and SHALL hold their last values in IDLE until the next result overwrites them.
REQ-023 Inputs a_i, b_i, sub_i, carry_i SHALL be ignored outside the IDLE handshake cycle; changes during RUN/DONE SHALL not affect the result.
REQ-024 Output handshake and new input handshake SHALL NOT occur in the same cycle: the block returns to IDLE first, so back-to-back throughput is one operation per WIDTH/4+2 cycles.
REQ-025 The nibble counter SHALL wrap cleanly: no extra RUN cycle, no counter overflow into DONE decoding.
REQ-026 Sub mode result SHALL equal (A - B) mod 2^WIDTH.

Reset
REQ-027 While rst_ni=0: state=IDLE, in_ready_o=0 during reset then 1 at the first edge after release, out_valid_o=0, sum_o=0, carry_o=0, overflow_o=0, counter and shift registers=0.
REQ-028 Reset asserted mid-RUN or in DONE SHALL abort the operation immediately; no result SHALL be presented after release.

Verification
REQ-029 Add 0xFFFFFFFF + 0x00000001, carry_i=0 -> after 8 cycles sum_o=0x00000000, carry_o=1, overflow_o=0.
REQ-030 Add 0x7FFFFFFF + 0x00000001, carry_i=0 -> sum_o=0x80000000, carry_o=0, overflow_o=1.
REQ-031 Sub 0x00000005 - 0x00000007 -> sum_o=0xFFFFFFFE, carry_o=0, overflow_o=0; sub 0x80000000 - 0x00000001 -> sum_o=0x7FFFFFFF, carry_o=1, overflow_o=1.
REQ-032 Backpressure: hold out_ready_i=0 for 5 cycles in DONE -> outputs stable, in_ready_o=0; driving new a_i/b_i meanwhile does not change sum_o.
REQ-033 Reset pulse in RUN cycle 4 -> out_valid_o never rises; next operation 0x12345678 + 0x11111111 yields 0x23456789.
REQ-034 Random 1000 operations (both modes, random carry_i, random ready stalls) -> every result matches a WIDTH-bit reference model; latency exactly 8 cycles each.
